// File: rtl/score_pkg.sv
// Shared types and helpers for the BCD score accumulator.
package score_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        COMMIT
    } state_t;

    // Packed BCD value with the lowest n digits set to 9.
    function automatic logic [31:0] bcd_all_nines(input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'h9;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with carry; shared serially by the accumulator.
module bcd_digit_add
    import score_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] s,
    output logic                   cout
);

    logic [BCD_DIGIT_W:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (raw > 5'd9) begin
            cout = 1'b1;
            s    = 4'(raw - 5'd10);
        end else begin
            cout = 1'b0;
            s    = raw[BCD_DIGIT_W-1:0];
        end
    end

endmodule

// File: rtl/bcd_score_accumulator.sv
// Game score accumulator: buffered weighted events, frame-timed combos,
// digit-serial BCD addition, saturation and a high-score register.
module bcd_score_accumulator
    import score_pkg::*;
#(
    parameter int                        NUM_DIGITS        = 4,
    parameter int                        NUM_EVENTS        = 3,
    parameter logic [8*NUM_EVENTS-1:0]   EVENT_WEIGHTS_BCD = {8'h10, 8'h05, 8'h01},
    parameter int                        COMBO_FRAMES      = 60,
    parameter int                        MAX_COMBO         = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               frame_start,
    input  logic [NUM_EVENTS-1:0]              event_pulse,
    input  logic                               clear_score,
    output logic [4*NUM_DIGITS-1:0]            score,
    output logic [4*NUM_DIGITS-1:0]            high_score,
    output logic [$clog2(MAX_COMBO+1)-1:0]     combo_level,
    output logic                               busy,
    output logic                               score_updated,
    output logic                               new_high,
    output logic                               saturated
);

    localparam int SW = BCD_DIGIT_W * NUM_DIGITS;
    localparam int CW = $clog2(MAX_COMBO + 1);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam logic [SW-1:0] NINES = SW'(bcd_all_nines(NUM_DIGITS));

    state_t                   state;
    logic [NUM_EVENTS-1:0]    pending;
    logic [NUM_EVENTS-1:0]    sel_mask;
    logic [7:0]               sel_weight;
    logic [7:0]               weight;
    logic [SW-1:0]            acc;
    logic [SW-1:0]            commit_value;
    logic [DW-1:0]            digit_idx;
    logic [CW-1:0]            pass_cnt;
    logic [CW-1:0]            next_combo;
    logic [7:0]               frame_cnt;
    logic                     carry;
    logic                     sat;
    logic [BCD_DIGIT_W-1:0]   acc_digit;
    logic [BCD_DIGIT_W-1:0]   weight_digit;
    logic [BCD_DIGIT_W-1:0]   sum_digit;
    logic                     carry_out;

    // Descending scan so the lowest-index pending channel wins.
    always_comb begin
        sel_mask   = '0;
        sel_weight = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_mask    = '0;
                sel_mask[i] = 1'b1;
                sel_weight  = EVENT_WEIGHTS_BCD[i*8 +: 8];
            end
        end
    end

    always_comb begin
        acc_digit    = acc[digit_idx*BCD_DIGIT_W +: BCD_DIGIT_W];
        weight_digit = (digit_idx == '0)     ? weight[3:0] :
                       (digit_idx == DW'(1)) ? weight[7:4] : 4'h0;
        commit_value = sat ? NINES : acc;
        if (frame_cnt < 8'(COMBO_FRAMES)) begin
            next_combo = (combo_level < CW'(MAX_COMBO)) ? combo_level + CW'(1) : CW'(MAX_COMBO);
        end else begin
            next_combo = '0;
        end
    end

    bcd_digit_add u_digit_add (
        .a    (acc_digit),
        .b    (weight_digit),
        .cin  (carry),
        .s    (sum_digit),
        .cout (carry_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pending       <= '0;
            weight        <= '0;
            acc           <= '0;
            digit_idx     <= '0;
            pass_cnt      <= '0;
            carry         <= 1'b0;
            sat           <= 1'b0;
            frame_cnt     <= 8'(COMBO_FRAMES);
            score         <= '0;
            high_score    <= '0;
            combo_level   <= '0;
            busy          <= 1'b0;
            score_updated <= 1'b0;
            new_high      <= 1'b0;
            saturated     <= 1'b0;
        end else if (clear_score) begin
            state         <= IDLE;
            pending       <= '0;
            frame_cnt     <= 8'(COMBO_FRAMES);
            score         <= '0;
            combo_level   <= '0;
            busy          <= 1'b0;
            score_updated <= 1'b0;
            new_high      <= 1'b0;
            saturated     <= 1'b0;
        end else begin
            score_updated <= 1'b0;
            new_high      <= 1'b0;
            pending       <= (pending & ~((state == IDLE) ? sel_mask : '0)) | event_pulse;

            if (state == IDLE && pending != '0) begin
                frame_cnt <= '0;
            end else if (frame_start && frame_cnt < 8'(COMBO_FRAMES)) begin
                frame_cnt <= frame_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (pending != '0) begin
                        combo_level <= next_combo;
                        weight      <= sel_weight;
                        acc         <= score;
                        digit_idx   <= '0;
                        pass_cnt    <= '0;
                        carry       <= 1'b0;
                        sat         <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ADD;
                    end
                end
                ADD: begin
                    acc[digit_idx*BCD_DIGIT_W +: BCD_DIGIT_W] <= sum_digit;
                    // A carry out of the top digit on any pass means overflow.
                    if (digit_idx == DW'(NUM_DIGITS - 1)) begin
                        carry     <= 1'b0;
                        digit_idx <= '0;
                        if (carry_out) begin
                            sat <= 1'b1;
                        end
                        if (pass_cnt == combo_level) begin
                            state <= COMMIT;
                        end else begin
                            pass_cnt <= pass_cnt + CW'(1);
                        end
                    end else begin
                        carry     <= carry_out;
                        digit_idx <= digit_idx + DW'(1);
                    end
                end
                COMMIT: begin
                    score         <= commit_value;
                    score_updated <= 1'b1;
                    if (sat) begin
                        saturated <= 1'b1;
                    end
                    if (commit_value > high_score) begin
                        high_score <= commit_value;
                        new_high   <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_score_accumulator.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// cycle by cycle against a decimal-arithmetic reference model.
module tb_bcd_score_accumulator;

    localparam int NUM_DIGITS   = 4;
    localparam int NUM_EVENTS   = 3;
    localparam int COMBO_FRAMES = 60;
    localparam int MAX_COMBO    = 3;
    localparam int MAX_SCORE    = 9999;
    localparam logic [8*NUM_EVENTS-1:0] WEIGHTS = {8'h10, 8'h05, 8'h01};

    int weight_dec [NUM_EVENTS] = '{1, 5, 10};

    logic                  clk;
    logic                  reset;
    logic                  frame_start;
    logic [NUM_EVENTS-1:0] event_pulse;
    logic                  clear_score;
    logic [15:0]           score;
    logic [15:0]           high_score;
    logic [1:0]            combo_level;
    logic                  busy;
    logic                  score_updated;
    logic                  new_high;
    logic                  saturated;

    int checks;
    int failures;

    int m_score, m_high, m_combo, m_frame, m_left, m_target;
    bit m_pending [NUM_EVENTS];
    bit m_sat, m_updated, m_newhigh;

    bcd_score_accumulator #(
        .NUM_DIGITS        (NUM_DIGITS),
        .NUM_EVENTS        (NUM_EVENTS),
        .EVENT_WEIGHTS_BCD (WEIGHTS),
        .COMBO_FRAMES      (COMBO_FRAMES),
        .MAX_COMBO         (MAX_COMBO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .event_pulse   (event_pulse),
        .clear_score   (clear_score),
        .score         (score),
        .high_score    (high_score),
        .combo_level   (combo_level),
        .busy          (busy),
        .score_updated (score_updated),
        .new_high      (new_high),
        .saturated     (saturated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic modelClear();
        m_score   = 0;
        m_combo   = 0;
        m_frame   = COMBO_FRAMES;
        m_left    = 0;
        m_sat     = 0;
        m_updated = 0;
        m_newhigh = 0;
        for (int i = 0; i < NUM_EVENTS; i++) m_pending[i] = 0;
    endtask

    // m_left counts the edges still owed to the add passes plus the commit.
    task automatic modelStep(input bit fs, input logic [NUM_EVENTS-1:0] ev, input bit clr);
        int sel;
        sel       = -1;
        m_updated = 0;
        m_newhigh = 0;
        if (clr) begin
            modelClear();
            return;
        end
        if (m_left == 0) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (m_pending[i] && sel < 0) sel = i;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_target > MAX_SCORE) begin
                    m_score = MAX_SCORE;
                    m_sat   = 1;
                end else begin
                    m_score = m_target;
                end
                m_updated = 1;
                if (m_score > m_high) begin
                    m_high    = m_score;
                    m_newhigh = 1;
                end
            end
        end
        if (sel >= 0) begin
            if (m_frame < COMBO_FRAMES) m_combo = (m_combo < MAX_COMBO) ? m_combo + 1 : MAX_COMBO;
            else m_combo = 0;
            m_target = m_score + weight_dec[sel] * (m_combo + 1);
            m_left   = NUM_DIGITS * (m_combo + 1) + 1;
            m_frame  = 0;
        end else if (fs && m_frame < COMBO_FRAMES) begin
            m_frame++;
        end
        for (int i = 0; i < NUM_EVENTS; i++) begin
            m_pending[i] = (m_pending[i] && i != sel) || ev[i];
        end
    endtask

    task automatic checkModel();
        checkOutput("score", 32'(score), to_bcd(m_score));
        checkOutput("high_score", 32'(high_score), to_bcd(m_high));
        checkOutput("combo_level", 32'(combo_level), 32'(m_combo));
        checkOutput("busy", 32'(busy), 32'(m_left != 0));
        checkOutput("score_updated", 32'(score_updated), 32'(m_updated));
        checkOutput("new_high", 32'(new_high), 32'(m_newhigh));
        checkOutput("saturated", 32'(saturated), 32'(m_sat));
    endtask

    task automatic applyStimulus(input bit fs, input logic [NUM_EVENTS-1:0] ev, input bit clr);
        frame_start = fs;
        event_pulse = ev;
        clear_score = clr;
        @(posedge clk);
        modelStep(fs, ev, clr);
        #1;
        checkModel();
        frame_start = 1'b0;
        event_pulse = '0;
        clear_score = 1'b0;
    endtask

    task automatic idleCycles(input int n, input int fs_every);
        for (int i = 0; i < n; i++) begin
            applyStimulus(fs_every > 0 && (i % fs_every) == 0, '0, 1'b0);
        end
    endtask

    initial begin
        int ripple_ch [14] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 1, 0, 0, 0, 0};
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        frame_start = 1'b0;
        event_pulse = '0;
        clear_score = 1'b0;
        m_high      = 0;
        modelClear();

        #12;
        checkOutput("rst_score", 32'(score), 32'h0);
        checkOutput("rst_high", 32'(high_score), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_sat", 32'(saturated), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] single event latency");
        applyStimulus(1'b0, 3'b001, 1'b0);
        idleCycles(5, 0);
        checkOutput("lat5_score", 32'(score), 32'h0);
        idleCycles(1, 0);
        checkOutput("lat6_score", 32'(score), 32'h0001);
        checkOutput("lat6_updated", 32'(score_updated), 32'h1);
        checkOutput("lat6_new_high", 32'(new_high), 32'h1);
        checkOutput("lat6_high", 32'(high_score), 32'h0001);
        checkOutput("lat6_combo", 32'(combo_level), 32'h0);
        idleCycles(3, 0);

        $display("[TB] simultaneous events on channels 1 and 2");
        applyStimulus(1'b0, 3'b000, 1'b1);
        applyStimulus(1'b0, 3'b110, 1'b0);
        idleCycles(40, 0);
        checkOutput("dual_score", 32'(score), 32'h0025);
        checkOutput("dual_combo", 32'(combo_level), 32'h1);

        $display("[TB] clear during add");
        applyStimulus(1'b0, 3'b000, 1'b1);
        applyStimulus(1'b0, 3'b001, 1'b0);
        idleCycles(3, 0);
        applyStimulus(1'b0, 3'b000, 1'b1);
        idleCycles(10, 0);
        checkOutput("clr_score", 32'(score), 32'h0);
        checkOutput("clr_high", 32'(high_score), 32'h0025);
        applyStimulus(1'b0, 3'b001, 1'b0);
        idleCycles(10, 0);
        checkOutput("clr_next_score", 32'(score), 32'h0001);
        checkOutput("clr_next_combo", 32'(combo_level), 32'h0);

        $display("[TB] combo ramp");
        applyStimulus(1'b0, 3'b000, 1'b1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 3'b001, 1'b0);
            idleCycles(20, 2);
        end
        checkOutput("combo_score", 32'(score), 32'h0018);
        checkOutput("combo_level_max", 32'(combo_level), 32'h3);
        idleCycles(120, 2);
        applyStimulus(1'b0, 3'b001, 1'b0);
        idleCycles(10, 0);
        checkOutput("combo_expired", 32'(combo_level), 32'h0);
        checkOutput("combo_expired_score", 32'(score), 32'h0019);

        $display("[TB] carry ripple");
        applyStimulus(1'b0, 3'b000, 1'b1);
        for (int k = 0; k < 14; k++) begin
            applyStimulus(1'b0, 3'(1 << ripple_ch[k]), 1'b0);
            idleCycles(65, 1);
        end
        checkOutput("ripple_pre", 32'(score), 32'h0099);
        applyStimulus(1'b0, 3'b001, 1'b0);
        idleCycles(65, 1);
        checkOutput("ripple_post", 32'(score), 32'h0100);

        $display("[TB] saturation");
        applyStimulus(1'b0, 3'b000, 1'b1);
        for (int k = 0; k < 251; k++) begin
            applyStimulus(1'b0, 3'b100, 1'b0);
            idleCycles(20, 0);
        end
        checkOutput("sat_9980", 32'(score), 32'h9980);
        idleCycles(65, 1);
        applyStimulus(1'b0, 3'b010, 1'b0);
        idleCycles(65, 1);
        applyStimulus(1'b0, 3'b100, 1'b0);
        idleCycles(65, 1);
        checkOutput("sat_9995", 32'(score), 32'h9995);
        checkOutput("sat_flag_low", 32'(saturated), 32'h0);
        applyStimulus(1'b0, 3'b100, 1'b0);
        idleCycles(65, 1);
        checkOutput("sat_9999", 32'(score), 32'h9999);
        checkOutput("sat_flag", 32'(saturated), 32'h1);
        applyStimulus(1'b0, 3'b001, 1'b0);
        idleCycles(65, 1);
        checkOutput("sat_hold", 32'(score), 32'h9999);

        $display("[TB] random traffic");
        applyStimulus(1'b0, 3'b000, 1'b1);
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(($urandom % 4) == 0,
                          (($urandom % 3) == 0) ? 3'($urandom) : 3'b000,
                          ($urandom % 400) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_score_accumulator.md
Name: bcd_score_accumulator

Overview:
Parametrised successor to the game score counter. Accumulates weighted game events directly in packed BCD, using a digit-serial adder instead of divide/modulo. Adds a pending-event buffer so simultaneous events are never lost, a frame-timed combo multiplier, saturation, and a high-score register. Sits between the collision/pickup detectors and the score display.

Parameters:
NUM_DIGITS, 4, BCD digits in score and high score (2..8)
NUM_EVENTS, 3, number of event input channels (1..8)
EVENT_WEIGHTS_BCD, {8'h10,8'h05,8'h01}, packed 2-digit BCD weight per channel; channel 0 is in the LSB byte
COMBO_FRAMES, 60, frame_start pulses within which a following event counts as a combo (1..255)
MAX_COMBO, 3, maximum combo level; add passes per event = combo_level+1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_start  in  1  one-cycle pulse per video frame
event_pulse  in  NUM_EVENTS  one-cycle event strobes, one bit per channel
clear_score  in  1  synchronous new-game clear
score  out  4*NUM_DIGITS  committed packed BCD score, digit 0 in the LSBs
high_score  out  4*NUM_DIGITS  packed BCD high score
combo_level  out  $clog2(MAX_COMBO+1)  combo level of the last accepted event
busy  out  1  FSM not in IDLE
score_updated  out  1  one-cycle pulse when score commits
new_high  out  1  one-cycle pulse when high_score changes
saturated  out  1  sticky: score clamped at all 9s

Behaviour:
- Reset (async, active-high): all outputs 0, pending 0, FSM in IDLE, frame counter = COMBO_FRAMES (no prior event).
- Pending buffer:
  - event_pulse[i] sets pending[i] on the next edge.
  - A pulse on an already-pending channel is absorbed (no count).
  - The bit is cleared when its channel is selected; a pulse arriving in the same cycle as that selection re-sets it.
- FSM IDLE:
  - If pending != 0, select the lowest-index pending channel.
  - Compute combo: if frame counter < COMBO_FRAMES, combo_level = min(combo_level+1, MAX_COMBO); otherwise 0.
  - Reset the frame counter to 0, copy score into the working accumulator, digit index = 0, go to ADD.
- FSM ADD, one digit per cycle:
  - Weight digit is 0 for indices >= 2. Digit sum = acc_digit + weight_digit + carry.
  - If sum > 9, subtract 10 and set carry.
  - After digit NUM_DIGITS-1: a carry out sets the sat flag for this event.
  - If passes remain, restart at digit 0; otherwise go to COMMIT.
  - Duration is NUM_DIGITS*(combo_level+1) cycles.
- FSM COMMIT, one cycle:
  - score <= sat ? all 9s : acc. The saturated output is set if sat. score_updated pulses.
  - If the committed value > high_score (unsigned compare of packed BCD), high_score <= value and new_high pulses in the same cycle.
  - Go to IDLE.
- Once saturated=1, further events still run the FSM but score stays all 9s.
- Latency: pulse at edge t; pending at t+1; IDLE selects in that cycle; score changes at edge t+2+NUM_DIGITS*(combo_level+1).
- Back-to-back: after COMMIT, IDLE serves the next pending channel immediately (no dead cycle beyond IDLE itself).
- Frame counter: increments on frame_start and saturates at COMBO_FRAMES.
- clear_score has highest priority and takes effect from any state. On the next edge:
  - score = 0, combo_level = 0, saturated = 0, pending = 0.
  - Frame counter = COMBO_FRAMES; FSM to IDLE, aborting any in-flight add with no commit.
  - high_score is kept.
  - event_pulse in the same cycle is dropped.
- All outputs are registered; no combinational path from input to output.

Decomposition:
- Package score_pkg: state enum {IDLE, ADD, COMMIT}, BCD_DIGIT_W=4, function bcd_all_nines(n).
- Sub-module bcd_digit_add: combinational 1-digit BCD add with carry in/out, instantiated once and shared serially.

Test Plan:
- Default parameters, single event_pulse[0], frame counter expired -> score=0x0001 after 6 cycles, score_updated 1 cycle, new_high=1, high_score=0x0001, combo_level=0.
- Pulse event_pulse[2] and event_pulse[1] in the same cycle from score 0, no frame_start between -> ch1 commits first (0x0005, combo 0), then ch2 with combo 1 adds 10 twice -> score=0x0025.
- Score 0x9995, event 2 -> carry out -> score=0x9999, saturated=1; a further event 0 leaves 0x9999.
- Score 0x0099, event 0 -> carries ripple across digits -> score=0x0100.
- clear_score asserted mid-ADD -> no score_updated, score=0, pending cleared, high_score unchanged; next event 0 -> 0x0001 with combo_level=0 and new_high=0.
- Six event_pulse[0] spaced 10 frames apart with COMBO_FRAMES=60 -> combo 0,1,2,3,3,3 -> adds 1,2,3,4,4,4 -> score=0x0018; a gap of 60 frames then resets combo to 0.
